// File: rtl/stack_ram_arbiter_if.sv
// Requester-side bundle for the stack RAM arbiter: toggle-protocol requests in,
// completion toggles, per-requester read data and status out.
interface stack_ram_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = 12,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_tgl;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    ack_tgl;
   logic [NREQ*DW-1:0] rdata;
   logic               busy;
   logic               err;

   modport master (
      output req_tgl, req_we, req_addr, req_wdata,
      input  ack_tgl, rdata, busy, err
   );

   modport slave (
      input  req_tgl, req_we, req_addr, req_wdata,
      output ack_tgl, rdata, busy, err
   );
endinterface

// File: rtl/stack_ram_arbiter.sv
// Round-robin arbiter sharing one single-port stack RAM between NREQ toggle-protocol
// requesters; each access takes IDLE -> ACCESS -> RESP (3 cycles).
module stack_ram_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 4000,
   parameter int AW    = 12,
   parameter int DW    = 32
) (
   input logic               clk,
   input logic               reset,
   stack_ram_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state;
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      cur_id;
   logic               cur_we;
   logic [AW-1:0]      cur_addr;
   logic [DW-1:0]      cur_wdata;
   logic [DW-1:0]      rd_data;
   logic [NREQ-1:0]    ack_q;
   logic [NREQ*DW-1:0] rdata_q;
   logic               busy_q;
   logic               err_q;

   logic [NREQ-1:0]    pending;
   logic               pick_valid;
   logic [IW-1:0]      pick_id;
   logic               in_range;

   logic [DW-1:0]      mem [DEPTH];

   assign pending  = bus.req_tgl ^ ack_q;
   assign in_range = (32'(cur_addr) < DEPTH);

   // Search starts one past the last grant so the just-served requester goes last.
   always_comb begin
      int idx;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pick_valid = 1'b0;
      pick_id    = '0;
      idx        = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!pick_valid && pending[idx]) begin
            pick_valid = 1'b1;
            pick_id    = IW'(idx);
         end
      end
   end

   // NOTE: RAM array has no reset; only the write enable is blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && state == ACCESS && in_range && cur_we)
         mem[cur_addr] <= cur_wdata;
      if (state == ACCESS)
         rd_data <= (in_range && !cur_we) ? mem[cur_addr] : '0;
   end

   // NOTE: all state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= IW'(NREQ - 1);
         cur_id     <= '0;
         cur_we     <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  cur_id    <= pick_id;
                  cur_we    <= bus.req_we[pick_id];
                  cur_addr  <= bus.req_addr[int'(pick_id)*AW +: AW];
                  cur_wdata <= bus.req_wdata[int'(pick_id)*DW +: DW];
                  busy_q    <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (!in_range)
                  err_q <= 1'b1;
               state <= RESP;
            end
            RESP: begin
               if (!cur_we)
                  rdata_q[int'(cur_id)*DW +: DW] <= rd_data;
               ack_q[cur_id] <= ~ack_q[cur_id];
               last_grant    <= cur_id;
               busy_q        <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack_tgl = ack_q;
   assign bus.rdata   = rdata_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_stack_ram_arbiter.sv
// Scoreboard bench for stack_ram_arbiter: stimulus pushes expected completions,
// a negedge monitor pops one on every ack toggle and checks id, cycle and rdata.
module tb_stack_ram_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 4000;
   localparam int AW    = 12;
   localparam int DW    = 32;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   exp_t          sb[$];
   logic [DW-1:0] model_rd [NREQ];
   logic [DW-1:0] w [4] = '{32'hA0A0_0100, 32'hB1B1_0101, 32'hC2C2_0102, 32'hD3D3_0103};

   stack_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   stack_ram_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input int id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      bus.req_we[id]             = we;
      bus.req_addr[id*AW +: AW]  = addr;
      bus.req_wdata[id*DW +: DW] = wd;
      bus.req_tgl[id]            = ~bus.req_tgl[id];
   endtask

   task automatic expect_done(input int id, input logic [DW-1:0] data, input int at, input bit is_read);
      exp_t e;
      if (is_read)
         model_rd[id] = data;
      e.id   = id;
      e.data = model_rd[id];
      e.cyc  = at;
      sb.push_back(e);
   endtask

   // For reads, d is the expected read word; for writes, it is the write data.
   task automatic req(input int id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                      input int lat);
      issue(id, we, addr, d);
      expect_done(id, d, cyc + lat, !we);
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 100 && sb.size() != 0; n++)
         step();
      check({name, "_drain"}, sb.size(), 0);
      check({name, "_busy"}, bus.busy, 1'b0);
   endtask

   // Monitor: every ack flip must match the head of the scoreboard.
   logic [NREQ-1:0] prev_ack = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.ack_tgl[i] != prev_ack[i]) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_ack: requester %0d at cycle %0d, none required", i, cyc);
               end else begin
                  e = sb.pop_front();
                  check("ack_id", i, e.id);
                  check("ack_cycle", cyc, e.cyc);
                  check("ack_rdata", bus.rdata[i*DW +: DW], e.data);
               end
            end
         end
      end
      prev_ack <= bus.ack_tgl;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int c1;
      int c2;
      bus.req_tgl   = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < NREQ; i++) model_rd[i] = '0;

      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      check("rst_ack", bus.ack_tgl, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err, 0);
      check("rst_rdata", |bus.rdata, 0);

      // Single requester write then read.
      step();
      req(0, 1'b1, 12'd5, 32'hDEAD_BEEF, 3);
      step();
      check("busy_active", bus.busy, 1'b1);
      drain("t1w");
      req(0, 1'b0, 12'd5, 32'hDEAD_BEEF, 3);
      drain("t1r");
      check("t1_err", bus.err, 0);

      // Preload through requester 3, leaving it as last grant, then four simultaneous reads.
      for (int i = 0; i < 4; i++) begin
         req(3, 1'b1, AW'(100 + i), w[i], 3);
         drain("t2pre");
      end
      for (int i = 0; i < 4; i++)
         req(i, 1'b0, AW'(100 + i), w[i], 3 * (i + 1));
      drain("t2");

      // Fairness: after a grant to 2, requesters 0 and 3 together -> 3 first.
      req(2, 1'b0, 12'd102, w[2], 3);
      drain("t3a");
      req(3, 1'b0, 12'd100, w[0], 3);
      req(0, 1'b0, 12'd101, w[1], 6);
      drain("t3b");

      // Requesters 1 and 2 re-toggle continuously: strict alternation 1,2,1,2...
      c = cyc;
      for (int k = 0; k < 16; k++)
         expect_done(1 + (k % 2), w[1 + (k % 2)], c + 3 + 3 * k, 1'b1);
      c1 = 0;
      c2 = 0;
      for (int n = 0; n < 80 && (c1 < 8 || c2 < 8); n++) begin
         if (bus.req_tgl[1] == bus.ack_tgl[1] && c1 < 8) begin
            issue(1, 1'b0, 12'd101, '0);
            c1++;
         end
         if (bus.req_tgl[2] == bus.ack_tgl[2] && c2 < 8) begin
            issue(2, 1'b0, 12'd102, '0);
            c2++;
         end
         step();
      end
      drain("t3alt");

      // Out-of-range accesses.
      req(0, 1'b1, 12'd3999, 32'hA5A5_0001, 3);
      drain("t4a");
      req(0, 1'b1, 12'd0, 32'hA5A5_0002, 3);
      drain("t4b");
      check("t4_err_pre", bus.err, 0);
      req(0, 1'b1, 12'd4000, 32'h0000_0BAD, 3);
      drain("t4c");
      check("t4_err_set", bus.err, 1);
      req(0, 1'b0, 12'd3999, 32'hA5A5_0001, 3);
      drain("t4d");
      req(0, 1'b0, 12'd0, 32'hA5A5_0002, 3);
      drain("t4e");
      req(1, 1'b0, 12'd4095, 32'h0, 3);
      drain("t4f");
      check("t4_err_sticky", bus.err, 1);

      // Write-then-read hazard with requester 0 as last grant.
      req(0, 1'b1, 12'd7, 32'h0000_FFFF, 3);
      drain("t5a");
      req(1, 1'b1, 12'd7, 32'h0000_0012, 3);
      req(2, 1'b0, 12'd7, 32'h0000_0012, 6);
      drain("t5b");
      check("t5_err_sticky", bus.err, 1);

      // Reset during ACCESS of a write of 0x55 to addr 9.
      req(0, 1'b1, 12'd9, 32'h0, 3);
      drain("t6a");
      issue(3, 1'b1, 12'd9, 32'h0000_0055);
      step();
      check("t6_busy_access", bus.busy, 1'b1);
      reset = 1'b1;
      step();
      check("t6_rst_ack", bus.ack_tgl, 0);
      check("t6_rst_busy", bus.busy, 0);
      check("t6_rst_err", bus.err, 0);
      check("t6_rst_rdata", |bus.rdata, 0);
      for (int i = 0; i < NREQ; i++) model_rd[i] = '0;
      // Requester 0 reads addr 9 ahead of the re-served requester 3.
      bus.req_tgl[2:0]       = 3'b001;
      bus.req_we[0]          = 1'b0;
      bus.req_addr[0 +: AW]  = 12'd9;
      reset = 1'b0;
      expect_done(0, 32'h0, cyc + 3, 1'b1);
      expect_done(3, 32'h0, cyc + 6, 1'b0);
      drain("t6b");
      req(0, 1'b0, 12'd9, 32'h0000_0055, 3);
      drain("t6c");
      check("t6_err", bus.err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stack_ram_arbiter.md
Name: stack_ram_arbiter

Overview:
- Shares one single-port word-addressed stack RAM between NREQ independent FSM datapaths.
- Each datapath uses the toggle-request protocol of the generated designs: a pending access exists while req_tgl[i] != ack_tgl[i].
- A round-robin scheduler serialises accesses, performs each one, returns read data, and flips the matching ack bit.
- Sits between the generated main FSMs and the stack RAM, which is instantiated inside this block.

Parameters:
NREQ, 4, number of requesters
DEPTH, 4000, RAM depth in 32-bit words
AW, 12, address width; must satisfy 2^AW >= DEPTH
DW, 32, data width

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous active-high reset
req_tgl  input  NREQ  per-requester request toggle
req_we  input  NREQ  1 = write, 0 = read; sampled at grant
req_addr  input  NREQ*AW  word address, requester i in bits [i*AW +: AW]
req_wdata  input  NREQ*DW  write data, requester i in bits [i*DW +: DW]
ack_tgl  output  NREQ  per-requester completion toggle
rdata  output  NREQ*DW  per-requester read-data register
busy  output  1  high when FSM is not IDLE
err  output  1  sticky out-of-range flag

Behaviour:
- pending[i] = req_tgl[i] ^ ack_tgl[i].
- A requester must hold req_we, req_addr and req_wdata stable from its toggle until its ack flips.
- Re-toggling while pending is a protocol violation. The arbiter does not detect it; result undefined.
- Reset values: ack_tgl=0, rdata=0, err=0, busy=0, FSM=IDLE, last_grant=NREQ-1 (so requester 0 has first priority). RAM contents are not reset.
- FSM states:
  - IDLE: if any pending, pick the first pending index searching last_grant+1, last_grant+2, ... modulo NREQ. Latch id, we, addr, wdata. Go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: if addr < DEPTH: write does mem[addr] <= wdata; read captures mem[addr] into an internal data register. If addr >= DEPTH: no RAM write, read data = 0, err <= 1. Go to RESP.
  - RESP: for a read, rdata[id] <= captured data; for a write, rdata[id] is unchanged. ack_tgl[id] flips, last_grant <= id. Go to IDLE.
- Latency: toggle at posedge T is sampled in IDLE at T+1. ACCESS at T+2, RESP at T+3. ack_tgl and rdata are visible after posedge T+3, i.e. 3 cycles.
- Throughput: one access per 3 cycles. With continuously pending requesters, grants rotate strictly; no requester waits more than NREQ-1 other accesses.
- Arbitration is evaluated only in IDLE. Requests arriving during ACCESS/RESP wait. The just-served requester's toggle is evaluated against its new ack value in the next IDLE.
- Ordering: accesses complete in grant order. A write granted before a read to the same address is visible to that read.
- rdata[i] holds its value until the next completed read by requester i.
- err is sticky and cleared only by reset.
- Reset mid-operation: FSM returns to IDLE, and all ack_tgl bits clear, so any requester whose req_tgl=1 is pending afterwards. An in-flight ACCESS write in the reset cycle is not performed (reset has priority).
- busy = (state != IDLE).
- Address arithmetic: unsigned compare against DEPTH; no wrap.

Test Plan:
- Single requester: req 0 writes 0xDEADBEEF to addr 5; ack_tgl[0] flips 3 cycles after the toggle. Then req 0 reads addr 5 -> rdata[0]=0xDEADBEEF, ack flips again, err=0.
- All four toggle in the same cycle, each reading a distinct preloaded address. Grants go 0,1,2,3; acks flip at +3, +6, +9, +12 cycles; each rdata[i] holds its own word.
- Fairness: last_grant=2, then 0 and 3 pending together -> 3 is served first, then 0. Requester 1 toggling repeatedly for 8 accesses while 2 is also pending -> strict alternation 1,2,1,2...
- Out of range: write to addr 4000 leaves mem[3999] and mem[0] unchanged, sets err=1. A read of addr 4095 returns rdata=0. err stays 1 through later good accesses until reset.
- Write-then-read hazard: req 1 writes 0x12 to addr 7 and req 2 reads addr 7, toggled together -> rdata[2]=0x12.
- Reset asserted during ACCESS of a write of 0x55 to addr 9 (mem[9] previously 0x0) -> mem[9] stays 0x0, ack_tgl=0, busy=0. The requester (req_tgl=1) is re-served after reset deasserts.
